vga_scanout: RTL and testbench
==============================

# vga_scanout

Raster timing generator and pixel output stage for the display path. It produces the `pixel_x_in`/`pixel_y_in` coordinates consumed by the memory/display block and samples that block's 12-bit `pixel` result. It drives the VGA RGB and sync pins and raises a one-cycle vblank interrupt pulse for the interrupt controller. Default timing is 640x480@60 from a 100 MHz system clock, using a divide-by-4 pixel tick.

## Interface
- `H_VISIBLE`, 640, visible pixels per line
- `H_FRONT`, 16, horizontal front porch (pixel ticks)
- `H_SYNC`, 96, hsync width
- `H_BACK`, 48, horizontal back porch
- `V_VISIBLE`, 480, visible lines
- `V_FRONT`, 10, vertical front porch (lines)
- `V_SYNC`, 2, vsync width
- `V_BACK`, 33, vertical back porch
- `PIX_DIV`, 4, clk cycles per pixel tick; must be ≥3, because the upstream pixel lookup has 2-clk latency

- `clk`  in  1  system clock
- `rst`  in  1  synchronous reset, active-high
- `pixel_x`  out  10  current horizontal count; goes to the display block's `pixel_x_in`
- `pixel_y`  out  10  current vertical count; goes to the display block's `pixel_y_in`
- `pixel_in`  in  12  RGB444 from the display block, laid out {R[11:8], G[7:4], B[3:0]}
- `vga_r`, `vga_g`, `vga_b`  out  4 each  registered colour
- `vga_hs`  out  1  horizontal sync, active-low
- `vga_vs`  out  1  vertical sync, active-low
- `vblank_irq`  out  1  one-clk pulse at the start of vblank
- `frame_count`  out  16  frames completed; wraps at 16'hFFFF→0

## Operation
- Derived constants:
  - H_TOTAL = sum of the H_* parameters (800).
  - V_TOTAL = sum of the V_* parameters (525).
- `div_cnt` counts 0..PIX_DIV-1. `tick` = (div_cnt == PIX_DIV-1).
- On `tick`, the counters advance:
  - `h_cnt` increments. At H_TOTAL-1 it wraps to 0 and `v_cnt` increments.
  - `v_cnt` wraps from V_TOTAL-1 to 0.
- `pixel_x` = `h_cnt` and `pixel_y` = `v_cnt`, driven directly from the counter registers. They are not masked outside the visible area.
- Region decode uses the counts held before the advance:
  - active = h < H_VISIBLE && v < V_VISIBLE
  - hsync region = H_VISIBLE+H_FRONT ≤ h < H_VISIBLE+H_FRONT+H_SYNC, i.e. 656..751
  - vsync region = V_VISIBLE+V_FRONT ≤ v < V_VISIBLE+V_FRONT+V_SYNC, i.e. 490..491
- On the same `tick` edge, the output stage registers:
  - {vga_r, vga_g, vga_b} ← active ? `pixel_in` : 12'h000
  - `vga_hs` ← ~hsync region
  - `vga_vs` ← ~vsync region
- Colour and sync are registered together, so they stay aligned with each other.
- Vblank event: `tick` && h == H_TOTAL-1 && v == V_VISIBLE-1.
  - `vblank_irq` = 1 for exactly that clk only.
  - `frame_count` increments on the same edge.
- All counters are unsigned. There is no saturation anywhere.

## Timing
- Reset values, one edge after `rst` is sampled high:
  - div_cnt = 0, h_cnt = 0, v_cnt = 0, so pixel_x = pixel_y = 0
  - rgb = 0
  - vga_hs = 1, vga_vs = 1
  - vblank_irq = 0, frame_count = 0
- Reset mid-frame: the same values apply on the next edge. Any in-flight pixel is discarded, and no irq fires on that edge even if the vblank condition held.
- Coordinates are stable for PIX_DIV clks. `pixel_in` is sampled PIX_DIV clks after the coordinates change, which leaves ≥1 clk of slack over the 2-clk upstream latency.
- Output latency: a coordinate pair's colour appears on the VGA pins one pixel period (PIX_DIV clks) after it is presented on `pixel_x`/`pixel_y`. It then holds for PIX_DIV clks.
- First `tick` after reset release is on the 4th rising edge (default PIX_DIV).
- Periods at default parameters:
  - line = 3200 clks
  - frame = 1,680,000 clks
  - hsync low = 384 clks
  - vsync low = 6400 clks
- `pixel_in` is ignored while not active; the output is forced to 0 during blanking.

## Test plan
- Reset: hold `rst` for 3 clks, then release → on the first edge after reset: rgb=0, hs=vs=1, irq=0, frame_count=0, pixel_x=pixel_y=0.
- First pixel: `pixel_in`=12'hABC constant after reset → rgb {A,B,C} at the 4th edge after release; pixel_x becomes 1 on the same edge.
- Hsync: measure from reset release → vga_hs falls at clk 4·657 = 2628, rises at 4·753 = 3012. Colour is 0 for h ≥ 640.
- Vblank: → vblank_irq is high for exactly one clk at clk 4·(480·800) = 1,536,000, frame_count = 1 then. After 3 frames frame_count = 3, with irq spacing exactly 1,680,000 clks.
- Vsync: → vga_vs is low for exactly 6400 clks, starting at line 490.
- Mid-frame reset: assert `rst` at v_cnt=479, h_cnt=799, on the tick clk → no irq pulse; all outputs at reset values on the next edge; frame_count stays 0.

Source files
------------

// File: rtl/vga_scanout_if.sv
// Display-path bundle between the scanout stage (master), the pixel
// lookup block and the VGA pins (slave side).
interface vga_scanout_if;
    logic [9:0]  pixel_x;
    logic [9:0]  pixel_y;
    logic [11:0] pixel_in;
    logic [3:0]  vga_r;
    logic [3:0]  vga_g;
    logic [3:0]  vga_b;
    logic        vga_hs;
    logic        vga_vs;
    logic        vblank_irq;
    logic [15:0] frame_count;

    modport master (
        output pixel_x, pixel_y, vga_r, vga_g, vga_b,
        output vga_hs, vga_vs, vblank_irq, frame_count,
        input  pixel_in
    );

    modport slave (
        input  pixel_x, pixel_y, vga_r, vga_g, vga_b,
        input  vga_hs, vga_vs, vblank_irq, frame_count,
        output pixel_in
    );
endinterface

// File: rtl/vga_scanout.sv
// Raster timing generator and registered RGB444/sync output stage with a
// one-clk vblank interrupt and a wrapping frame counter.
module vga_scanout #(
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33,
    parameter int PIX_DIV   = 4
) (
    input  logic          clk,
    input  logic          rst,
    vga_scanout_if.master vif
);
    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int DW      = $clog2(PIX_DIV);

    localparam logic [DW-1:0] DIV_LAST = DW'(PIX_DIV - 1);
    localparam logic [9:0] H_LAST  = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST  = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS   = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS   = 10'(V_VISIBLE);
    localparam logic [9:0] HS_BEG  = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] HS_END  = 10'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [9:0] VS_BEG  = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] VS_END  = 10'(V_VISIBLE + V_FRONT + V_SYNC);
    localparam logic [9:0] V_VLAST = 10'(V_VISIBLE - 1);

    logic [DW-1:0] div_cnt;
    logic [9:0]    h_cnt;
    logic [9:0]    v_cnt;
    logic [11:0]   rgb_q;
    logic          hs_q;
    logic          vs_q;
    logic          irq_q;
    logic [15:0]   frame_q;

    logic tick;
    logic active;
    logic hs_region;
    logic vs_region;
    logic vblank_evt;

    // Decode uses the counts held before this tick's advance.
    always_comb begin
        tick       = (div_cnt == DIV_LAST);
        active     = (h_cnt < H_VIS) && (v_cnt < V_VIS);
        hs_region  = (h_cnt >= HS_BEG) && (h_cnt < HS_END);
        vs_region  = (v_cnt >= VS_BEG) && (v_cnt < VS_END);
        vblank_evt = tick && (h_cnt == H_LAST) && (v_cnt == V_VLAST);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt <= '0;
            h_cnt   <= '0;
            v_cnt   <= '0;
            rgb_q   <= '0;
            hs_q    <= 1'b1;
            vs_q    <= 1'b1;
            irq_q   <= 1'b0;
            frame_q <= '0;
        end else begin
            irq_q <= vblank_evt;
            if (tick) begin
                div_cnt <= '0;
                if (h_cnt == H_LAST) begin
                    h_cnt <= '0;
                    v_cnt <= (v_cnt == V_LAST) ? 10'd0 : v_cnt + 10'd1;
                end else begin
                    h_cnt <= h_cnt + 10'd1;
                end
                rgb_q <= active ? vif.pixel_in : 12'h000;
                hs_q  <= ~hs_region;
                vs_q  <= ~vs_region;
                if (vblank_evt) frame_q <= frame_q + 16'd1;
            end else begin
                div_cnt <= div_cnt + {{(DW-1){1'b0}}, 1'b1};
            end
        end
    end

    assign vif.pixel_x     = h_cnt;
    assign vif.pixel_y     = v_cnt;
    assign vif.vga_r       = rgb_q[11:8];
    assign vif.vga_g       = rgb_q[7:4];
    assign vif.vga_b       = rgb_q[3:0];
    assign vif.vga_hs      = hs_q;
    assign vif.vga_vs      = vs_q;
    assign vif.vblank_irq  = irq_q;
    assign vif.frame_count = frame_q;
endmodule

// File: tb/tb_vga_scanout.sv
// Bench for vga_scanout on a shrunken raster (15x8 ticks, 480 clks/frame),
// checked every cycle against a tick-index model plus literal pins.
module tb_vga_scanout;
  localparam int HV = 8, HF = 2, HS = 3, HB = 2;
  localparam int VV = 4, VF = 1, VS = 2, VB = 1;
  localparam int PD = 4;
  localparam int HT = HV + HF + HS + HB;
  localparam int VT = VV + VF + VS + VB;
  localparam int F = HT * VT;
  localparam int IDX = VV * HT - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic const_mode = 1'b1;
  int e = 0;
  logic [11:0] last_cap = 12'h000;
  logic chk_en = 1'b0;
  int n_chk = 0;
  int n_fail = 0;
  int irq_seen[$];
  logic [31:0] exp_q[$];

  vga_scanout_if vif ();

  vga_scanout #(
    .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .PIX_DIV(PD)
  ) dut (
    .clk(clk),
    .rst(rst),
    .vif(vif)
  );

  // clock / reset block
  always #5 clk = ~clk;

  function automatic logic [11:0] pat(input logic [9:0] x, input logic [9:0] y);
    return {y[3:0], x[3:0], x[3:0] ^ y[3:0]};
  endfunction

  assign vif.pixel_in = const_mode ? 12'hABC : pat(vif.pixel_x, vif.pixel_y);

  // edge count since reset and the pixel value present at each tick edge
  always @(posedge clk) begin
    if (rst) begin
      e <= 0;
    end else begin
      if (e % PD == PD - 1) last_cap <= vif.pixel_in;
      e <= e + 1;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at e=%0d: got %0d expected %0d", name, e, act, exp);
    end
  endtask

  // scoreboard: model derived from the tick index p = e / PD
  int m_p, m_q, m_qh, m_qv;
  int x_exp, y_exp, rgb_exp, hs_exp, vs_exp, irq_exp, fc_exp;
  always @(negedge clk) begin
    if (chk_en) begin
      m_p   = e / PD;
      x_exp = (m_p % F) % HT;
      y_exp = (m_p % F) / HT;
      if (m_p == 0) begin
        rgb_exp = 0; hs_exp = 1; vs_exp = 1;
      end else begin
        m_q  = (m_p - 1) % F;
        m_qh = m_q % HT;
        m_qv = m_q / HT;
        rgb_exp = (m_qh < HV && m_qv < VV) ? int'(last_cap) : 0;
        hs_exp  = (m_qh >= HV + HF && m_qh < HV + HF + HS) ? 0 : 1;
        vs_exp  = (m_qv >= VV + VF && m_qv < VV + VF + VS) ? 0 : 1;
      end
      irq_exp = (m_p > 0 && e % PD == 0 && (m_p - 1) % F == IDX) ? 1 : 0;
      fc_exp  = (m_p > IDX) ? (((m_p - 1 - IDX) / F + 1) % 65536) : 0;
      chk("pixel_x", int'(vif.pixel_x), x_exp);
      chk("pixel_y", int'(vif.pixel_y), y_exp);
      chk("rgb", int'({vif.vga_r, vif.vga_g, vif.vga_b}), rgb_exp);
      chk("vga_hs", int'(vif.vga_hs), hs_exp);
      chk("vga_vs", int'(vif.vga_vs), vs_exp);
      chk("vblank_irq", int'(vif.vblank_irq), irq_exp);
      chk("frame_count", int'(vif.frame_count), fc_exp);
      if (vif.vblank_irq) irq_seen.push_back(e);
    end
  end

  // driver tasks
  task automatic wait_e(input int t);
    int budget = 5000;
    while (e < t && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    chk("wait_e_reached", e, t);
  endtask

  task automatic do_reset(input int cycles);
    @(negedge clk);
    rst = 1'b1;
    repeat (cycles) @(posedge clk);
    @(negedge clk);
    irq_seen.delete();
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_x"}, int'(vif.pixel_x), 0);
    chk({tag, "_y"}, int'(vif.pixel_y), 0);
    chk({tag, "_rgb"}, int'({vif.vga_r, vif.vga_g, vif.vga_b}), 0);
    chk({tag, "_hs"}, int'(vif.vga_hs), 1);
    chk({tag, "_vs"}, int'(vif.vga_vs), 1);
    chk({tag, "_irq"}, int'(vif.vblank_irq), 0);
    chk({tag, "_fc"}, int'(vif.frame_count), 0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    chk_en = 1'b1;
    @(negedge clk);
    check_reset_vals("rst");
    rst = 1'b0;

    // first pixel with a constant source
    wait_e(3);
    chk("first_rgb_pre", int'({vif.vga_r, vif.vga_g, vif.vga_b}), 0);
    chk("first_x_pre", int'(vif.pixel_x), 0);
    wait_e(4);
    chk("first_rgb", int'({vif.vga_r, vif.vga_g, vif.vga_b}), 12'hABC);
    chk("first_x", int'(vif.pixel_x), 1);
    wait_e(6);
    const_mode = 1'b0;

    // hsync edges: fall at 4*11, rise at 4*14
    wait_e(43); chk("hs_before_fall", int'(vif.vga_hs), 1);
    wait_e(44); chk("hs_fall", int'(vif.vga_hs), 0);
    chk("rgb_blank", int'({vif.vga_r, vif.vga_g, vif.vga_b}), 0);
    wait_e(55); chk("hs_before_rise", int'(vif.vga_hs), 0);
    wait_e(56); chk("hs_rise", int'(vif.vga_hs), 1);

    // vblank interrupt at 4*(4*15)
    wait_e(239); chk("irq_pre", int'(vif.vblank_irq), 0);
    wait_e(240); chk("irq_hit", int'(vif.vblank_irq), 1);
    chk("fc_one", int'(vif.frame_count), 1);
    wait_e(241); chk("irq_post", int'(vif.vblank_irq), 0);

    // vsync low for 2 lines = 120 clks starting at line 5
    wait_e(303); chk("vs_before_fall", int'(vif.vga_vs), 1);
    wait_e(304); chk("vs_fall", int'(vif.vga_vs), 0);
    wait_e(423); chk("vs_before_rise", int'(vif.vga_vs), 0);
    wait_e(424); chk("vs_rise", int'(vif.vga_vs), 1);

    // three frames: irq every 480 clks
    wait_e(1201);
    chk("fc_three", int'(vif.frame_count), 3);
    exp_q = '{32'd240, 32'd720, 32'd1200};
    chk("irq_count", irq_seen.size(), exp_q.size());
    while (exp_q.size() > 0 && irq_seen.size() > 0) begin
      chk("irq_edge", irq_seen.pop_front(), int'(exp_q.pop_front()));
    end

    // mid-frame reset on the vblank tick of the first frame
    do_reset(1);
    check_reset_vals("rst2");
    rst = 1'b0;
    wait_e(239);
    chk("mid_x", int'(vif.pixel_x), HT - 1);
    chk("mid_y", int'(vif.pixel_y), VV - 1);
    rst = 1'b1;
    @(negedge clk);
    check_reset_vals("mid_rst");
    rst = 1'b0;
    wait_e(200);
    chk("mid_no_irq", irq_seen.size(), 0);
    chk("mid_fc", int'(vif.frame_count), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
